ps2_frame_receiver: RTL and testbench
=====================================

Name: ps2_frame_receiver

Overview:
Device-to-host half of the PS/2 core. Deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop) sent by a keyboard/mouse. Delivers each byte with a one-cycle strobe and flags parity, framing and timeout faults. Runs beside the host-to-device command transmitter on the same PS2_CLK/PS2_DAT pair. It is disabled while that transmitter owns the bus.

Parameters:
CLOCK_CYCLES_FOR_2MS, 100000, frame timeout in clk cycles (50 MHz); benches override to 50
NUMBER_OF_BITS_FOR_2MS, 17, width of the timeout counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
ps2_clk_posedge  in  1  one-cycle pulse, synchronised PS2_CLK rising edge (shared edge detector)
ps2_clk_negedge  in  1  one-cycle pulse, synchronised PS2_CLK falling edge
ps2_data  in  1  synchronised PS2_DAT level
receive_enable  in  1  high = receiver may listen; low while the command transmitter is active
received_data  out  8  last good byte; holds until the next good frame
received_data_en  out  1  one-cycle strobe, received_data updated
parity_error  out  1  one-cycle pulse, frame parity not odd
framing_error  out  1  one-cycle pulse, start or stop bit wrong
timeout_error  out  1  one-cycle pulse, frame exceeded timeout
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at posedge clk): state IDLE; all outputs 0; shift register, bit counter and timeout counter 0. Applies mid-frame and discards the partial frame.
- Bits are sampled only on cycles with ps2_clk_negedge==1. ps2_clk_posedge is unused apart from being a port for symmetry.
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - negedge && ps2_data==0 && receive_enable goes to DATA, with bit counter cleared.
  - negedge with ps2_data==1 stays in IDLE and raises framing_error.
  - While receive_enable==0, all edges are ignored.
- DATA: on each negedge, shift ps2_data into bit 7 of the shift register with a right shift, so the LSB arrives first. Bit counter increments 0 to 7. The negedge where counter==7 goes to PARITY.
- PARITY: on negedge, capture the parity bit and go to STOP.
- STOP: on negedge, evaluate the frame and return to IDLE.
  - Good frame: stop==1 and XOR(data, parity)==1. received_data is loaded and received_data_en pulses on the next cycle, giving 1-cycle latency from the stop-bit negedge.
  - stop==0: framing_error pulses and the data is discarded.
  - Parity bad with stop==1: parity_error pulses and the data is discarded.
  - Parity bad and stop==0: both pulses fire together.
- Timeout counter:
  - Cleared in IDLE.
  - Increments every clk in DATA/PARITY/STOP and saturates at CLOCK_CYCLES_FOR_2MS.
  - When counter==CLOCK_CYCLES_FOR_2MS and there is no negedge that cycle, go to IDLE and pulse timeout_error once.
  - A negedge in the same cycle takes priority over the timeout.
- receive_enable falling mid-frame: next state is IDLE, no flags, data discarded, because the host has taken the bus.
- All output pulses are registered, last exactly one cycle, and never repeat for one frame.
- A new start bit is accepted on the first negedge after returning to IDLE. Back-to-back frames need no gap cycles.
- Undefined state encodings recover to IDLE.

Decomposition:
- Shared package ps2_pkg holds:
  - the state encodings (2-bit)
  - constants PS2_DATA_BITS=8 and PS2_PARITY_ODD=1
  - function odd_parity_ok(data, parity)
  - the command transmitter uses the same parity function.
- One natural sub-module: ps2_timeout_counter (clear, enable, saturating compare, done output). It is reusable by the transmitter's 15 ms and 2 ms waits.

Test Plan:
- Send 0xFA (bits 0,1,0,1,1,1,1,1 LSB first, parity 1, stop 1) → received_data=0xFA, received_data_en high exactly 1 cycle, 1 cycle after the stop negedge; no error flags.
- Send 0xAA with parity 0 → parity_error pulses once; received_data_en stays 0; received_data keeps its previous value 0xFA.
- Send 0x55 (parity 1) with stop bit 0 → framing_error pulses once; no strobe. Then send 0x00 (parity 1) → received_data=0x00 with a strobe.
- CLOCK_CYCLES_FOR_2MS=50; send start + 4 data bits, then stop clocking → timeout_error pulses once ~51 cycles after the start edge; busy drops; next full frame 0x12 is received correctly.
- Drop receive_enable after 3 data bits → immediate IDLE, no flags. Raise it again and clock a full 0xFA frame → received normally.
- Assert reset=0 mid-frame (during PARITY) → all outputs 0 next cycle, state IDLE. A following 0x34 frame (parity 0) → good strobe.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encodings, frame constants and the
// odd-parity check used by both the receiver and the command transmitter.
package ps2_pkg;

    localparam int   PS2_DATA_BITS  = 8;
    localparam logic PS2_PARITY_ODD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // A PS/2 frame is good when data bits plus parity bit hold an odd count of ones
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     parity);
        return ((^data) ^ parity) == PS2_PARITY_ODD;
    endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// Saturating cycle counter for PS/2 bus waits; done_o holds once MAX_COUNT is reached
// and stays there until cleared.
module ps2_timeout_counter #(
    parameter int MAX_COUNT = 100000,
    parameter int WIDTH     = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic done_o
);

    logic [WIDTH-1:0] count_q;

    assign done_o = (count_q == WIDTH'(MAX_COUNT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && !done_o) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ps2_frame_receiver.sv
// Device-to-host PS/2 receiver: deserialises start/8 data/odd parity/stop frames
// on PS2_CLK falling edges and reports good bytes or parity/framing/timeout faults.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int CLOCK_CYCLES_FOR_2MS   = 100000,
    parameter int NUMBER_OF_BITS_FOR_2MS = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps2_clk_posedge,
    input  logic                     ps2_clk_negedge,
    input  logic                     ps2_data,
    input  logic                     receive_enable,
    output logic [PS2_DATA_BITS-1:0] received_data,
    output logic                     received_data_en,
    output logic                     parity_error,
    output logic                     framing_error,
    output logic                     timeout_error,
    output logic                     busy
);

    localparam int CNT_W = $clog2(PS2_DATA_BITS);

    ps2_state_e               state_q, state_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]         bitCount_q, bitCount_d;
    logic                     parity_q, parity_d;
    logic [PS2_DATA_BITS-1:0] data_q, data_d;
    logic                     dataEn_q, dataEn_d;
    logic                     parityErr_q, parityErr_d;
    logic                     framingErr_q, framingErr_d;
    logic                     timeoutErr_q, timeoutErr_d;
    logic                     inIdle;
    logic                     inFrame;
    logic                     timeoutDone;
    logic                     parityOk;
    logic                     unusedPosedge;

    // Rising edges carry no information for device-to-host traffic
    assign unusedPosedge = ps2_clk_posedge;

    assign inIdle   = (state_q == ST_IDLE);
    assign inFrame  = !inIdle;
    assign parityOk = odd_parity_ok(shift_q, parity_q);

    ps2_timeout_counter #(
        .MAX_COUNT(CLOCK_CYCLES_FOR_2MS),
        .WIDTH    (NUMBER_OF_BITS_FOR_2MS)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear_i (inIdle),
        .enable_i(inFrame),
        .done_o  (timeoutDone)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bitCount_q   <= '0;
            parity_q     <= 1'b0;
            data_q       <= '0;
            dataEn_q     <= 1'b0;
            parityErr_q  <= 1'b0;
            framingErr_q <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bitCount_q   <= bitCount_d;
            parity_q     <= parity_d;
            data_q       <= data_d;
            dataEn_q     <= dataEn_d;
            parityErr_q  <= parityErr_d;
            framingErr_q <= framingErr_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    // Losing the bus to the transmitter outranks a sampled edge, which outranks the timeout
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bitCount_d   = bitCount_q;
        parity_d     = parity_q;
        data_d       = data_q;
        dataEn_d     = 1'b0;
        parityErr_d  = 1'b0;
        framingErr_d = 1'b0;
        timeoutErr_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (receive_enable && ps2_clk_negedge) begin
                    if (!ps2_data) begin
                        state_d    = ST_DATA;
                        bitCount_d = '0;
                    end else begin
                        framingErr_d = 1'b1;
                    end
                end
            end
            ST_DATA, ST_PARITY, ST_STOP: begin
                if (!receive_enable) begin
                    state_d = ST_IDLE;
                end else if (ps2_clk_negedge) begin
                    if (state_q == ST_DATA) begin
                        shift_d    = {ps2_data, shift_q[PS2_DATA_BITS-1:1]};
                        bitCount_d = bitCount_q + CNT_W'(1);
                        if (bitCount_q == CNT_W'(PS2_DATA_BITS - 1)) begin
                            state_d = ST_PARITY;
                        end
                    end else if (state_q == ST_PARITY) begin
                        parity_d = ps2_data;
                        state_d  = ST_STOP;
                    end else begin
                        state_d      = ST_IDLE;
                        framingErr_d = !ps2_data;
                        parityErr_d  = !parityOk;
                        if (ps2_data && parityOk) begin
                            data_d   = shift_q;
                            dataEn_d = 1'b1;
                        end
                    end
                end else if (timeoutDone) begin
                    state_d      = ST_IDLE;
                    timeoutErr_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign received_data    = data_q;
    assign received_data_en = dataEn_q;
    assign parity_error     = parityErr_q;
    assign framing_error    = framingErr_q;
    assign timeout_error    = timeoutErr_q;
    assign busy             = inFrame;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Randomised self-checking bench for ps2_frame_receiver against a frame-level
// model that collects sampled bits in a queue and judges whole frames.
module tb_ps2_frame_receiver;

    localparam int TIMEOUT = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk_posedge;
    logic       ps2_clk_negedge;
    logic       ps2_data;
    logic       receive_enable;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       parity_error;
    logic       framing_error;
    logic       timeout_error;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit checking   = 1'b0;

    bit         inFrame = 1'b0;
    int         frameStart = 0;
    bit         bitQ[$];
    logic [7:0] modelData = 8'h00;
    bit         expEn, expPerr, expFerr, expTerr, expBusy;

    ps2_frame_receiver #(
        .CLOCK_CYCLES_FOR_2MS  (TIMEOUT),
        .NUMBER_OF_BITS_FOR_2MS(17)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ps2_clk_posedge (ps2_clk_posedge),
        .ps2_clk_negedge (ps2_clk_negedge),
        .ps2_data        (ps2_data),
        .receive_enable  (receive_enable),
        .received_data   (received_data),
        .received_data_en(received_data_en),
        .parity_error    (parity_error),
        .framing_error   (framing_error),
        .timeout_error   (timeout_error),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // One clock of stimulus; the model then decides what the next sample must show
    task automatic applyStimulus(input bit e, input bit d, input bit en, input bit rn);
        int         p;
        logic [7:0] b;
        int         ones;
        @(negedge clk);
        ps2_clk_negedge = e;
        ps2_data        = d;
        receive_enable  = en;
        reset           = rn;
        ps2_clk_posedge = !e && ($urandom_range(0, 3) == 0);
        p       = cyc + 1;
        expEn   = 1'b0;
        expPerr = 1'b0;
        expFerr = 1'b0;
        expTerr = 1'b0;
        if (!rn) begin
            inFrame   = 1'b0;
            modelData = 8'h00;
        end else if (!inFrame) begin
            if (en && e) begin
                if (!d) begin
                    inFrame    = 1'b1;
                    frameStart = p;
                    bitQ.delete();
                end else begin
                    expFerr = 1'b1;
                end
            end
        end else if (!en) begin
            inFrame = 1'b0;
        end else if (e) begin
            bitQ.push_back(d);
            if (bitQ.size() == 10) begin
                for (int i = 0; i < 8; i++) b[i] = bitQ[i];
                ones = $countones(b) + int'(bitQ[8]);
                if (!bitQ[9]) expFerr = 1'b1;
                if (ones % 2 == 0) expPerr = 1'b1;
                if (bitQ[9] && (ones % 2 == 1)) begin
                    expEn     = 1'b1;
                    modelData = b;
                end
                inFrame = 1'b0;
            end
        end else if (p - frameStart >= TIMEOUT + 1) begin
            expTerr = 1'b1;
            inFrame = 1'b0;
        end
        expBusy  = inFrame;
        checking = 1'b1;
    endtask

    // Sends the first nBits of start/data/parity/stop with random idle gaps between edges
    task automatic sendFrame(input logic [7:0] b, input bit par, input bit stp,
                             input int nBits, input int maxGap, input int lastGap);
        bit bits[11];
        int gap;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        bits[9]  = par;
        bits[10] = stp;
        for (int k = 0; k < nBits; k++) begin
            gap = (k == nBits - 1 && lastGap >= 0) ? lastGap : int'($urandom_range(0, maxGap));
            repeat (gap) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            applyStimulus(1'b1, bits[k], 1'b1, 1'b1);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic bit goodParity(input logic [7:0] b);
        return ~^b;
    endfunction

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (checking) begin
            checkOutput("received_data_en", received_data_en, expEn);
            checkOutput("received_data", received_data, modelData);
            checkOutput("parity_error", parity_error, expPerr);
            checkOutput("framing_error", framing_error, expFerr);
            checkOutput("timeout_error", timeout_error, expTerr);
            checkOutput("busy", busy, expBusy);
        end
    end

    initial begin
        int         tSeen;
        int         startCyc;
        int         kind;
        int         nb;
        logic [7:0] rb;
        bit         rp, rs;

        reset           = 1'b0;
        receive_enable  = 1'b0;
        ps2_clk_negedge = 1'b0;
        ps2_clk_posedge = 1'b0;
        ps2_data        = 1'b1;

        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_data", received_data, 0);

        sendFrame(8'hFA, 1'b1, 1'b1, 11, 3, -1);
        settle();
        checkOutput("fa_strobe", received_data_en, 1);
        checkOutput("fa_data", received_data, 32'hFA);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        checkOutput("fa_strobe_one_cycle", received_data_en, 0);

        sendFrame(8'hAA, 1'b0, 1'b1, 11, 3, -1);
        settle();
        checkOutput("aa_parity_error", parity_error, 1);
        checkOutput("aa_no_strobe", received_data_en, 0);
        checkOutput("aa_data_held", received_data, 32'hFA);

        sendFrame(8'h55, 1'b1, 1'b0, 11, 3, -1);
        settle();
        checkOutput("55_framing_error", framing_error, 1);
        checkOutput("55_no_strobe", received_data_en, 0);
        sendFrame(8'h00, 1'b1, 1'b1, 11, 3, -1);
        settle();
        checkOutput("00_data", received_data, 0);
        checkOutput("00_strobe", received_data_en, 1);

        sendFrame(8'h3C, 1'b1, 1'b1, 5, 2, -1);
        startCyc = frameStart;
        tSeen    = -1;
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
            settle();
            if (timeout_error && tSeen < 0) tSeen = cyc;
        end
        checkOutput("timeout_latency", tSeen - startCyc, TIMEOUT + 1);
        checkOutput("timeout_busy", busy, 0);
        sendFrame(8'h12, 1'b1, 1'b1, 11, 3, -1);
        settle();
        checkOutput("12_data", received_data, 32'h12);

        sendFrame(8'hE7, 1'b1, 1'b1, 4, 3, -1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        settle();
        checkOutput("disable_busy", busy, 0);
        repeat (5) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        sendFrame(8'hFA, 1'b1, 1'b1, 11, 3, -1);
        settle();
        checkOutput("reenable_fa_data", received_data, 32'hFA);

        sendFrame(8'h9C, 1'b1, 1'b1, 9, 3, -1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        settle();
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_data", received_data, 0);
        sendFrame(8'h34, 1'b0, 1'b1, 11, 3, -1);
        settle();
        checkOutput("34_data", received_data, 32'h34);
        checkOutput("34_strobe", received_data_en, 1);

        sendFrame(8'hC3, goodParity(8'hC3), 1'b1, 11, 0, 41);
        settle();
        checkOutput("edge_beats_timeout_data", received_data, 32'hC3);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            rb   = 8'($urandom_range(0, 255));
            rp   = ($urandom_range(0, 6) == 0) ? !goodParity(rb) : goodParity(rb);
            rs   = ($urandom_range(0, 6) != 0);
            if (kind == 0) begin
                applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
            end else if (kind == 1) begin
                nb = $urandom_range(1, 10);
                sendFrame(rb, rp, rs, nb, 3, -1);
                repeat (60) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            end else if (kind == 2) begin
                nb = $urandom_range(1, 10);
                sendFrame(rb, rp, rs, nb, 3, -1);
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
                applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
            end else begin
                sendFrame(rb, rp, rs, 11, 3, -1);
            end
        end

        repeat (5) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
